// File: rtl/uncache_store_buffer_if.sv
// Signal bundle for uncache_store_buffer: cache request/response, AXI-adapter read/write, status.
// slave = the store buffer itself, master = the cache/adapter environment driving it.
interface uncache_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_op;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [1:0]            req_size;
  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic [1:0]            rd_size;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic [DATA_W-1:0]     ret_data;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_wstrb;
  logic                  wr_rdy;
  logic                  wr_valid;
  logic                  buf_empty;
  logic                  buf_full;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size,
    input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    output req_ready, resp_valid, resp_rdata,
    output rd_req, rd_addr, rd_size,
    output wr_req, wr_addr, wr_data, wr_wstrb,
    output buf_empty, buf_full
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size,
    output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    input  req_ready, resp_valid, resp_rdata,
    input  rd_req, rd_addr, rd_size,
    input  wr_req, wr_addr, wr_data, wr_wstrb,
    input  buf_empty, buf_full
  );
endinterface

// File: rtl/uncache_store_buffer.sv
// Posted-write FIFO for uncached stores with strictly ordered uncached loads.
// Optional store merging into the tail-most entry when UNCACHE_SB_MERGE_EN is defined.
module uncache_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                   clk,
  input logic                   resetn,
  uncache_store_buffer_if.slave bus
);
  localparam int unsigned SW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_REQ  = 2'd1;
  localparam logic [1:0] D_WAIT = 2'd2;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_REQ  = 2'd1;
  localparam logic [1:0] L_WAIT = 2'd2;
  localparam logic [1:0] L_RESP = 2'd3;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [SW-1:0]     mem_strb [DEPTH];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [1:0]        drain_state;
  logic [1:0]        load_state;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        rd_size_q;
  logic [DATA_W-1:0] rdata_q;

  logic full;
  logic empty;
  logic load_idle;
  logic merge_hit;
  logic store_ok;
  logic load_ok;
  logic push;
  logic pop;
  logic load_acc;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0) && (drain_state == D_IDLE);
  assign load_idle = (load_state == L_IDLE);

`ifdef UNCACHE_SB_MERGE_EN
  logic [PW-1:0] last;
  logic          merge;
  assign last = tail - PW'(1);
  // The head entry is frozen once its write has been presented to the adapter.
  assign merge_hit = (count != '0)
                  && (mem_addr[last][ADDR_W-1:2] == bus.req_addr[ADDR_W-1:2])
                  && !((last == head) && (drain_state != D_IDLE));
  assign merge = bus.req_valid && bus.req_op && store_ok && merge_hit;
`else
  assign merge_hit = 1'b0;
`endif

  assign store_ok      = load_idle && (!full || merge_hit);
  assign load_ok       = load_idle && empty;
  assign bus.req_ready = bus.req_op ? store_ok : load_ok;
  assign push          = bus.req_valid && bus.req_op && store_ok && !merge_hit;
  assign load_acc      = bus.req_valid && !bus.req_op && load_ok;
  assign pop           = (drain_state == D_WAIT) && bus.wr_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= bus.req_addr;
      mem_data[tail] <= bus.req_wdata;
      mem_strb[tail] <= bus.req_wstrb;
    end
`ifdef UNCACHE_SB_MERGE_EN
    else if (merge) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (bus.req_wstrb[i]) mem_data[last][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
      end
      mem_strb[last] <= mem_strb[last] | bus.req_wstrb;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drain_state <= D_IDLE;
    end else begin
      case (drain_state)
        D_IDLE:  if (count != '0) drain_state <= D_REQ;
        D_REQ:   if (bus.wr_rdy) drain_state <= D_WAIT;
        D_WAIT:  if (bus.wr_valid) drain_state <= D_IDLE;
        default: drain_state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_state <= L_IDLE;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rdata_q    <= '0;
    end else begin
      case (load_state)
        L_IDLE: if (load_acc) begin
          rd_addr_q  <= bus.req_addr;
          rd_size_q  <= bus.req_size;
          load_state <= L_REQ;
        end
        L_REQ:  if (bus.rd_rdy) load_state <= L_WAIT;
        L_WAIT: if (bus.ret_valid) begin
          rdata_q    <= bus.ret_data;
          load_state <= L_RESP;
        end
        L_RESP: load_state <= L_IDLE;
      endcase
    end
  end

  // Head entry cannot change while in D_REQ, so the write fields stay stable.
  assign bus.wr_req     = (drain_state == D_REQ);
  assign bus.wr_addr    = bus.wr_req ? mem_addr[head] : '0;
  assign bus.wr_data    = bus.wr_req ? mem_data[head] : '0;
  assign bus.wr_wstrb   = bus.wr_req ? mem_strb[head] : '0;
  assign bus.rd_req     = (load_state == L_REQ);
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_size    = rd_size_q;
  assign bus.resp_valid = (load_state == L_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.buf_empty  = empty;
  assign bus.buf_full   = full;
endmodule

// File: tb/tb_uncache_store_buffer.sv
// Directed bench for uncache_store_buffer (DEPTH=4): cycle table plus burst, merge and reset sequences.
module tb_uncache_store_buffer;
  logic clk = 1'b0;
  logic resetn;

  uncache_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  uncache_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic op; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [1:0] size;
    logic rd_rdy; logic ret_valid; logic [31:0] ret_data; logic wr_rdy; logic wr_valid;
    logic e_ready; logic e_wr_req; logic [31:0] e_wr_addr; logic [31:0] e_wr_data; logic [3:0] e_wr_strb;
    logic e_rd_req; logic [31:0] e_rd_addr; logic [1:0] e_rd_size;
    logic e_resp; logic [31:0] e_rdata; logic e_empty; logic e_full;
  } vec_t;

  localparam logic [31:0] Z32 = 32'h0;
  localparam int NV = 21;

  vec_t vecs [NV];
  int checks   = 0;
  int failures = 0;

  logic [31:0] obs_addr [8];
  logic [31:0] obs_data [8];
  logic [3:0]  obs_strb [8];
  int          nw;
  logic        pend;
  logic        acc5;
  logic        done;
  int          pops;

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%0h exp=0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.req_size = '0; bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0;
    bus.ret_data = '0; bus.wr_rdy = 1'b0; bus.wr_valid = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_addr = a;
    bus.req_wdata = d; bus.req_wstrb = s; bus.req_size = 2'd2;
  endtask

  // Acts as the write side of the adapter until the buffer drains, logging each write.
  task automatic service(input int unsigned max_cycles, input string tag);
    logic p;
    logic fin;
    p = 1'b0; fin = 1'b0; nw = 0;
    for (int unsigned c = 0; c < max_cycles && !fin; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.wr_rdy    = 1'b1;
      bus.wr_valid  = p;
      p = 1'b0;
      #1;
      if (bus.wr_req) begin
        if (nw < 8) begin
          obs_addr[nw] = bus.wr_addr; obs_data[nw] = bus.wr_data; obs_strb[nw] = bus.wr_wstrb;
        end
        nw++;
        p = 1'b1;
      end
      if (bus.buf_empty && !p) fin = 1'b1;
    end
    bus.wr_rdy = 1'b0;
    check({tag, "_drained"}, 0, 64'(fin), 64'd1);
  endtask

  always @(negedge clk) begin
    #3;
    if (resetn === 1'b1) check("rd_wr_exclusive", 0, 64'(bus.rd_req & bus.wr_req), 64'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // v, op, addr, wdata, strb, size, rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    // e_ready, e_wr_req, e_wr_addr, e_wr_data, e_wr_strb, e_rd_req, e_rd_addr, e_rd_size, e_resp, e_rdata, e_empty, e_full
    vecs[0]  = '{1'b1,1'b1,32'h1FAF_0000,32'hDEAD_BEEF,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b1,32'h1FAF_0000,32'hDEAD_BEEF,4'hF, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b1,1'b0, 1'b0,1'b1,32'h1FAF_0000,32'hDEAD_BEEF,4'hF, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b1, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b1,32'h1FD0_0100,32'h0000_0001,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b1,32'h1FD0_0104,32'h0000_0002,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b1,1'b0, 1'b0,1'b1,32'h1FD0_0100,32'h0000_0001,4'hF, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b1, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b1,1'b0, 1'b0,1'b1,32'h1FD0_0104,32'h0000_0002,4'hF, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[13] = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b1, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,32'h1FD0_03F8,Z32,4'h0,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[15] = '{1'b1,1'b1,32'h1FAF_0020,32'h1234_5678,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b1,32'h1FD0_03F8,2'd2, 1'b0,Z32, 1'b1,1'b0};
    vecs[16] = '{1'b1,1'b1,32'h1FAF_0020,32'h1234_5678,4'hF,2'd2, 1'b1,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b1,32'h1FD0_03F8,2'd2, 1'b0,Z32, 1'b1,1'b0};
    vecs[17] = '{1'b1,1'b1,32'h1FAF_0020,32'h1234_5678,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[18] = '{1'b1,1'b1,32'h1FAF_0020,32'h1234_5678,4'hF,2'd2, 1'b0,1'b1,32'h0000_0055, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};
    vecs[19] = '{1'b1,1'b1,32'h1FAF_0020,32'h1234_5678,4'hF,2'd2, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b0,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b1,32'h0000_0055, 1'b1,1'b0};
    vecs[20] = '{1'b0,1'b1,Z32,Z32,4'h0,2'd0, 1'b0,1'b0,Z32, 1'b0,1'b0, 1'b1,1'b0,Z32,Z32,4'h0, 1'b0,Z32,2'd0, 1'b0,Z32, 1'b1,1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("rst_empty",      0, 64'(bus.buf_empty),  64'd1);
    check("rst_full",       0, 64'(bus.buf_full),   64'd0);
    check("rst_wr_req",     0, 64'(bus.wr_req),     64'd0);
    check("rst_rd_req",     0, 64'(bus.rd_req),     64'd0);
    check("rst_resp_valid", 0, 64'(bus.resp_valid), 64'd0);
    check("rst_wr_addr",    0, 64'(bus.wr_addr),    64'd0);
    check("rst_rd_addr",    0, 64'(bus.rd_addr),    64'd0);
    check("rst_resp_rdata", 0, 64'(bus.resp_rdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].v;      bus.req_op   = vecs[i].op;    bus.req_addr  = vecs[i].addr;
      bus.req_wdata = vecs[i].wdata;  bus.req_wstrb = vecs[i].strb; bus.req_size  = vecs[i].size;
      bus.rd_rdy    = vecs[i].rd_rdy; bus.ret_valid = vecs[i].ret_valid; bus.ret_data = vecs[i].ret_data;
      bus.wr_rdy    = vecs[i].wr_rdy; bus.wr_valid  = vecs[i].wr_valid;
      #1;
      check("req_ready",  i, 64'(bus.req_ready),  64'(vecs[i].e_ready));
      check("wr_req",     i, 64'(bus.wr_req),     64'(vecs[i].e_wr_req));
      check("rd_req",     i, 64'(bus.rd_req),     64'(vecs[i].e_rd_req));
      check("resp_valid", i, 64'(bus.resp_valid), 64'(vecs[i].e_resp));
      check("buf_empty",  i, 64'(bus.buf_empty),  64'(vecs[i].e_empty));
      check("buf_full",   i, 64'(bus.buf_full),   64'(vecs[i].e_full));
      if (vecs[i].e_wr_req) begin
        check("wr_addr",  i, 64'(bus.wr_addr),  64'(vecs[i].e_wr_addr));
        check("wr_data",  i, 64'(bus.wr_data),  64'(vecs[i].e_wr_data));
        check("wr_wstrb", i, 64'(bus.wr_wstrb), 64'(vecs[i].e_wr_strb));
      end
      if (vecs[i].e_rd_req) begin
        check("rd_addr", i, 64'(bus.rd_addr), 64'(vecs[i].e_rd_addr));
        check("rd_size", i, 64'(bus.rd_size), 64'(vecs[i].e_rd_size));
      end
      if (vecs[i].e_resp) check("resp_rdata", i, 64'(bus.resp_rdata), 64'(vecs[i].e_rdata));
    end
    @(negedge clk);
    idle_inputs();

    // Burst: fill all four entries with the adapter stalled, then hold a fifth store.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_store(32'h1FAF_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      #1 check("burst_ready", i, 64'(bus.req_ready), 64'd1);
    end
    @(negedge clk);
    drive_store(32'h1FAF_1010, 32'hA000_0004, 4'hF);
    #1;
    check("burst_full_ready", 4, 64'(bus.req_ready), 64'd0);
    check("burst_full_flag",  4, 64'(bus.buf_full),  64'd1);
    pend = 1'b0; acc5 = 1'b0; done = 1'b0; pops = 0; nw = 0;
    for (int unsigned c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      bus.wr_rdy    = 1'b1;
      bus.wr_valid  = pend;
      pend          = 1'b0;
      bus.req_valid = !acc5;
      #1;
      if (bus.wr_valid && !acc5) check("burst_pop_cycle_ready", pops, 64'(bus.req_ready), 64'd0);
      if (bus.req_valid && bus.req_ready) begin
        acc5 = 1'b1;
        check("burst_fifth_after_pop", 0, 64'(pops >= 1), 64'd1);
      end
      if (bus.wr_valid) pops++;
      if (bus.wr_req) begin
        if (nw < 8) begin
          obs_addr[nw] = bus.wr_addr; obs_data[nw] = bus.wr_data; obs_strb[nw] = bus.wr_wstrb;
        end
        nw++;
        pend = 1'b1;
      end
      if (acc5 && bus.buf_empty && !pend) done = 1'b1;
    end
    idle_inputs();
    check("burst_done",    0, 64'(done), 64'd1);
    check("burst_nwrites", 0, 64'(nw),   64'd5);
    for (int i = 0; i < 5; i++) begin
      check("burst_order_addr", i, 64'(obs_addr[i]), 64'(32'h1FAF_1000 + 32'(4 * i)));
      check("burst_order_data", i, 64'(obs_data[i]), 64'(32'hA000_0000 + 32'(i)));
    end

    // Merge: two partial stores to one word while an earlier entry is on the bus.
    @(negedge clk);
    drive_store(32'h1FAF_0000, 32'hAAAA_AAAA, 4'hF);
    #1 check("merge_s0_ready", 0, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive_store(32'h1FAF_0010, 32'h0000_0011, 4'h1);
    #1 check("merge_s1_ready", 0, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drive_store(32'h1FAF_0010, 32'h0000_2200, 4'h2);
    #1;
    check("merge_s2_ready",    0, 64'(bus.req_ready), 64'd1);
    check("merge_s2_draining", 0, 64'(bus.wr_req),    64'd1);
    service(40, "merge");
    check("merge_w0_addr", 0, 64'(obs_addr[0]), 64'(32'h1FAF_0000));
    check("merge_w0_data", 0, 64'(obs_data[0]), 64'(32'hAAAA_AAAA));
`ifdef UNCACHE_SB_MERGE_EN
    check("merge_nwrites", 0, 64'(nw),          64'd2);
    check("merge_w1_addr", 1, 64'(obs_addr[1]), 64'(32'h1FAF_0010));
    check("merge_w1_data", 1, 64'(obs_data[1]), 64'(32'h0000_2211));
    check("merge_w1_strb", 1, 64'(obs_strb[1]), 64'(4'h3));
`else
    check("merge_nwrites", 0, 64'(nw),          64'd3);
    check("merge_w1_data", 1, 64'(obs_data[1]), 64'(32'h0000_0011));
    check("merge_w1_strb", 1, 64'(obs_strb[1]), 64'(4'h1));
    check("merge_w2_addr", 2, 64'(obs_addr[2]), 64'(32'h1FAF_0010));
    check("merge_w2_data", 2, 64'(obs_data[2]), 64'(32'h0000_2200));
    check("merge_w2_strb", 2, 64'(obs_strb[2]), 64'(4'h2));
`endif

    // Reset while a write is outstanding with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_rdy = 1'b1;
      drive_store(32'h1FAF_2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid_pre_wait",  0, 64'(bus.wr_req),    64'd0);
    check("rst_mid_pre_empty", 0, 64'(bus.buf_empty), 64'd0);
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_wr_req", 0, 64'(bus.wr_req),    64'd0);
    check("rst_mid_empty",  0, 64'(bus.buf_empty), 64'd1);
    check("rst_mid_full",   0, 64'(bus.buf_full),  64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_rdy   = 1'b1;
      bus.wr_valid = 1'b1;
      #1;
      check("rst_after_wr_req", i, 64'(bus.wr_req),    64'd0);
      check("rst_after_empty",  i, 64'(bus.buf_empty), 64'd1);
    end
    idle_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uncache_store_buffer.md
Name: uncache_store_buffer

Overview:
- Parametrised uncached-access bridge between the DCache uncached path and the AXI uncache adapter.
- Generalises the single-transaction uncache channel to a DEPTH-entry posted-write FIFO.
- Stores retire to the CPU in one cycle and drain to AXI in order.
- Uncached loads are strictly ordered behind all buffered stores, because device registers cannot tolerate reordering.

Parameters:
DEPTH, 4, number of store entries; power of two, >=2
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  cache issues uncached access
req_op  in  1  0 load, 1 store
req_addr  in  ADDR_W  physical address
req_wdata  in  DATA_W  store data
req_wstrb  in  DATA_W/8  store byte enables
req_size  in  2  load size: 0 byte, 1 half, 2 word
req_ready  out  1  access accepted this cycle when req_valid&&req_ready
resp_valid  out  1  load data valid, one-cycle pulse
resp_rdata  out  DATA_W  load data
rd_req  out  1  AXI read request
rd_addr  out  ADDR_W  read address
rd_size  out  2  read size (copy of req_size)
rd_rdy  in  1  adapter accepts read
ret_valid  in  1  read data returned
ret_data  in  DATA_W  read data
wr_req  out  1  AXI write request
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_wstrb  out  DATA_W/8  write strobes
wr_rdy  in  1  adapter accepts write
wr_valid  in  1  write response (completion)
buf_empty  out  1  count==0 and drain FSM idle
buf_full  out  1  count==DEPTH

Behaviour:
- Reset values (async, resetn=0): head=tail=count=0; drain FSM D_IDLE; load FSM L_IDLE. rd_req, wr_req, resp_valid all 0. Address/data outputs 0. buf_empty=1, buf_full=0.
- Storage: entry = {addr, data, wstrb}. Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- Store acceptance: req_ready = !buf_full && load FSM==L_IDLE. On accept, the entry is written at tail, tail++, count++.
- Load acceptance: req_ready = buf_empty && load FSM==L_IDLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Drain FSM, D_IDLE:
  - count>0 -> D_REQ.
- Drain FSM, D_REQ:
  - wr_req=1; wr_addr/wr_data/wr_wstrb are driven from the head entry and held stable.
  - wr_rdy -> D_WAIT.
- Drain FSM, D_WAIT:
  - wr_req=0.
  - wr_valid -> pop (head++, count--), then -> D_IDLE.
- Drain latency: a store accepted in cycle t produces wr_req no earlier than t+2. One write is outstanding at a time.
- Load FSM, L_IDLE:
  - Load accepted -> latch addr/size, -> L_REQ.
- Load FSM, L_REQ:
  - rd_req=1 with latched addr/size.
  - rd_rdy -> L_WAIT.
- Load FSM, L_WAIT:
  - ret_valid -> register ret_data.
  - resp_valid=1 for exactly one cycle next cycle, then -> L_IDLE.
- Ordering:
  - A load never issues while any store is buffered or draining.
  - No store is accepted while a load is outstanding.
  - rd_req and wr_req are never asserted together.
- Full: further stores are held (req_ready=0) until a pop. In the same cycle as the pop, req_ready stays 0, because buf_full is registered state.
- Reset mid-operation: all state is cleared immediately and the outstanding AXI transaction is abandoned. The AXI adapter shares resetn.
- ret_valid/wr_valid arriving in an unexpected state are ignored.

Optional Feature:
UNCACHE_SB_MERGE_EN
- Defined: a store whose word address (addr[ADDR_W-1:2]) equals the tail-most valid entry merges into that entry. For each set strobe bit, the byte is overwritten and the strobe is ORed in. No new entry is allocated. Merging is allowed when full.
- Merging is not allowed into the head entry while the drain FSM is in D_REQ or D_WAIT.
- Undefined: every store allocates its own entry.

Test Plan:
- Single store 0x1FAF_0000, data 0xDEAD_BEEF, strb 0xF -> req_ready=1; wr_req at t+2 with identical fields; wr_rdy then wr_valid -> buf_empty=1.
- Store burst with wr_rdy=0: 4 stores (DEPTH=4) -> all accepted; 5th store sees req_ready=0; release wr_rdy -> 4 writes in FIFO order; 5th accepted after first pop.
- Load behind 2 stores to 0x1FD0_03F8 -> load held (req_ready=0) until both wr_valid; then rd_req, rd_addr=0x1FD0_03F8; ret_data=0x0000_0055 -> resp_valid pulse, resp_rdata=0x55.
- Store while load is outstanding -> req_ready=0 until resp_valid.
- resetn pulled low while in D_WAIT with 3 entries -> wr_req=0 and buf_empty=1 immediately; after release, no write is issued.
- MERGE_EN: stores to 0x1FAF_0010 with strb 0x1/data 0x11 then strb 0x2/data 0x2200, while wr_rdy=0 and draining an earlier entry -> one entry, wr_data 0x0000_2211, wr_wstrb 0x3. Without the macro -> two writes.
